// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// -----------------------------------------------------------------------------
// ID-stage hazard detector built on a per-register scoreboard. Every register
// write in flight is tracked as a pending bit and a latency countdown. The
// block detects RAW, WAW and multiplier structural hazards from that state and
// drives the pipeline stall and bubble controls.
//
// Configuration macro: HAZARD_SCOREBOARD_FORWARD_EN
//   defined   : a consumer may issue once the producer's result can be taken
//               from the forwarding network.
//   undefined : a consumer waits until the producer's writeback clears the
//               pending bit.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid                   ID holds a valid instruction
//   id_rs1/_used, id_rs2/_used source addresses and their read enables
//   id_rd, id_wb_en            destination address and its write enable
//   id_kind                    00 ALU, 01 LOAD, 10 MUL, 11 no result
//   flush                      redirect; the ID instruction is squashed
//   wb_valid, wb_rd            writeback commit port
//   pc_en, if_id_en            front-end advance enables
//   id_ex_bubble               insert a NOP into ID/EX
//   issue                      the ID instruction issues this cycle
//   stall_cnt                  saturating count of stall cycles
//
// Countdown convention: cd[r] is loaded with the producer latency at issue and
// decrements once per cycle. A value of 1 therefore means the result reaches
// the bypass during the current cycle, in time for an instruction issued now.
// The cycles still to wait are cd-1, which is why the RAW (forwarding) and the
// structural checks compare against 1 and the WAW check compares against the
// new instruction's own latency.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int REG_AW      = 3,
    parameter int LAT_ALU     = 1,
    parameter int LAT_LOAD    = 2,
    parameter int LAT_MUL     = 3,
    parameter int CNT_W       = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic                   id_rs1_used,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic                   id_rs2_used,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_wb_en,
    input  logic [1:0]             id_kind,
    input  logic                   flush,
    input  logic                   wb_valid,
    input  logic [REG_AW-1:0]      wb_rd,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_bubble,
    output logic                   issue,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int NREG = 1 << REG_AW;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'b00,
        KIND_LOAD = 2'b01,
        KIND_MUL  = 2'b10,
        KIND_NONE = 2'b11
    } kind_e;

    logic [NREG-1:0]        pending_q, pending_d;
    logic [CNT_W-1:0]       cd_q [NREG];
    logic [CNT_W-1:0]       cd_d [NREG];
    logic [CNT_W-1:0]       mul_busy_q, mul_busy_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    kind_e            kind;
    logic [CNT_W-1:0] id_lat;
    logic             raw, waw, strct, need_stall, records;

    function automatic logic [CNT_W-1:0] lat_of(input kind_e k);
        case (k)
            KIND_ALU:  lat_of = CNT_W'(LAT_ALU);
            KIND_LOAD: lat_of = CNT_W'(LAT_LOAD);
            KIND_MUL:  lat_of = CNT_W'(LAT_MUL);
            default:   lat_of = '0;
        endcase
    endfunction

    // Hazard on one source register; r0 is hardwired zero and never hazards.
    function automatic logic src_hz(input logic [REG_AW-1:0] s, input logic used);
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
        src_hz = used && (s != '0) && pending_q[s] && (cd_q[s] > CNT_W'(1));
`else
        src_hz = used && (s != '0) && pending_q[s];
`endif
    endfunction

    always_comb begin
        kind   = kind_e'(id_kind);
        id_lat = lat_of(kind);
        raw    = src_hz(id_rs1, id_rs1_used) || src_hz(id_rs2, id_rs2_used);
        // The new write must land strictly after the older one to keep
        // writebacks in order.
        waw    = id_wb_en && (id_rd != '0) && pending_q[id_rd] && (cd_q[id_rd] > id_lat);
        strct  = (kind == KIND_MUL) && (mul_busy_q > CNT_W'(1));
        // A flush squashes the instruction, so it never reports a stall.
        need_stall = id_valid && !flush && (raw || waw || strct);
        // Gated by reset so nothing claims to issue while state is held clear.
        issue        = rst_n && id_valid && !flush && !need_stall;
        pc_en        = !need_stall;
        if_id_en     = !need_stall;
        id_ex_bubble = need_stall || flush;
        records      = issue && id_wb_en && (id_rd != '0) && (kind != KIND_NONE);
    end

    // NOTE: every next-state variable gets its hold/default value first, so no
    // path through this block can leave one unassigned and infer a latch.
    always_comb begin
        pending_d = pending_q;
        for (int r = 0; r < NREG; r++) begin
            cd_d[r] = (cd_q[r] != '0) ? cd_q[r] - CNT_W'(1) : '0;
        end
        mul_busy_d = (mul_busy_q != '0) ? mul_busy_q - CNT_W'(1) : '0;

        if (wb_valid && (wb_rd != '0)) begin
            pending_d[wb_rd] = 1'b0;
        end
        // Issue comes after writeback so a same-cycle issue to the same rd wins.
        if (records) begin
            pending_d[id_rd] = 1'b1;
            cd_d[id_rd]      = id_lat;
        end
        if (issue && (kind == KIND_MUL)) begin
            mul_busy_d = CNT_W'(LAT_MUL);
        end

        stall_cnt_d = stall_cnt_q;
        if (need_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // NOTE: the countdown array is a handful of flops, not a RAM, and must read
    // as idle straight out of reset, so it is reset along with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            mul_busy_q  <= '0;
            stall_cnt_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                cd_q[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge value, independent of statement order.
            pending_q   <= pending_d;
            mul_busy_q  <= mul_busy_d;
            stall_cnt_q <= stall_cnt_d;
            for (int r = 0; r < NREG; r++) begin
                cd_q[r] <= cd_d[r];
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard (default parameters). Inputs change
// 1 ns after the rising edge; outputs are checked 1 ns later, mid-cycle.
module tb_hazard_scoreboard;

    localparam logic [1:0] K_ALU  = 2'b00;
    localparam logic [1:0] K_LOAD = 2'b01;
    localparam logic [1:0] K_MUL  = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_rs1_used, id_rs2_used, id_wb_en, flush, wb_valid;
    logic [2:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic [1:0]  id_kind;
    logic        pc_en, if_id_en, id_ex_bubble, issue;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs1_used  (id_rs1_used),
        .id_rs2       (id_rs2),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_wb_en     (id_wb_en),
        .id_kind      (id_kind),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_bubble (id_ex_bubble),
        .issue        (issue),
        .stall_cnt    (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one ID instruction: valid, kind, rd, wb_en, rs1, rs1_used, rs2, rs2_used.
    task automatic set_id(input logic v, input logic [1:0] k, input logic [2:0] rd,
                          input logic wb, input logic [2:0] s1, input logic u1,
                          input logic [2:0] s2, input logic u2);
        id_valid    = v;
        id_kind     = k;
        id_rd       = rd;
        id_wb_en    = wb;
        id_rs1      = s1;
        id_rs1_used = u1;
        id_rs2      = s2;
        id_rs2_used = u2;
    endtask

    task automatic idle();
        set_id(1'b0, K_ALU, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        flush    = 1'b0;
        wb_valid = 1'b0;
        wb_rd    = 3'd0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    // Expected stalled-cycle output pattern.
    task automatic expect_stall(input string tag);
        check({tag, "_pc_en"}, 32'(pc_en), 32'd0);
        check({tag, "_bubble"}, 32'(id_ex_bubble), 32'd1);
        check({tag, "_issue"}, 32'(issue), 32'd0);
    endtask

    initial begin
        // ---- reset state, inputs idle
        idle();
        rst_n = 1'b0;
        #2;
        check("rst_pc_en", 32'(pc_en), 32'd1);
        check("rst_if_id_en", 32'(if_id_en), 32'd1);
        check("rst_bubble", 32'(id_ex_bubble), 32'd0);
        check("rst_issue", 32'(issue), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        #1;

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
        // ---- LOAD r2 then ADD r4,r2,r1: one stall cycle
        do_reset();
        set_id(1'b1, K_LOAD, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        #1 check("fwd_load_issue", 32'(issue), 32'd1);
        step();
        set_id(1'b1, K_ALU, 3'd4, 1'b1, 3'd2, 1'b1, 3'd1, 1'b1);
        #1 expect_stall("fwd_ld_use");
        step();
        check("fwd_ld_use_issue", 32'(issue), 32'd1);
        step();
        idle();
        #1 check("fwd_ld_stall_cnt", 32'(stall_cnt), 32'd1);

        // ---- back-to-back dependent ALU ops: no stall
        do_reset();
        set_id(1'b1, K_ALU, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        step();
        set_id(1'b1, K_ALU, 3'd2, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0);
        #1 check("fwd_alu_alu_issue", 32'(issue), 32'd1);
        step();
        idle();
`else
        // ---- ADD r1, writeback three cycles later; consumer stalls 3 cycles
        do_reset();
        set_id(1'b1, K_ALU, 3'd1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        #1 check("nofwd_add_issue", 32'(issue), 32'd1);
        step();
        set_id(1'b1, K_ALU, 3'd2, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0);
        #1 expect_stall("nofwd_c1");
        step();
        expect_stall("nofwd_c2");
        step();
        wb_valid = 1'b1;
        wb_rd    = 3'd1;
        #1 expect_stall("nofwd_c3_wb");
        step();
        wb_valid = 1'b0;
        #1 check("nofwd_issue_after_wb", 32'(issue), 32'd1);
        check("nofwd_pc_en_after_wb", 32'(pc_en), 32'd1);
        step();
        idle();
        #1 check("nofwd_stall_cnt", 32'(stall_cnt), 32'd3);
`endif

        // ---- MUL r5 then independent MUL r6: two structural stall cycles
        do_reset();
        set_id(1'b1, K_MUL, 3'd5, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        #1 check("mul1_issue", 32'(issue), 32'd1);
        step();
        set_id(1'b1, K_MUL, 3'd6, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        #1 expect_stall("mul2_c1");
        step();
        expect_stall("mul2_c2");
        step();
        check("mul2_issue", 32'(issue), 32'd1);
        check("mul2_bubble", 32'(id_ex_bubble), 32'd0);
        step();
        idle();
        #1 check("mul_stall_cnt", 32'(stall_cnt), 32'd2);

        // ---- MUL r2 then ALU writing r2: WAW until cd[r2] <= LAT_ALU
        do_reset();
        set_id(1'b1, K_MUL, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        step();
        set_id(1'b1, K_ALU, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        #1 expect_stall("waw_c1");
        step();
        expect_stall("waw_c2");
        step();
        check("waw_issue", 32'(issue), 32'd1);
        step();
        idle();
        #1 check("waw_stall_cnt", 32'(stall_cnt), 32'd2);

        // ---- register 0 never hazards (write or read)
        do_reset();
        set_id(1'b1, K_MUL, 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        step();
        set_id(1'b1, K_ALU, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1);
        #1 check("r0_issue", 32'(issue), 32'd1);
        check("r0_pc_en", 32'(pc_en), 32'd1);
        step();
        idle();

        // ---- flush with a hazarding instruction in ID
        do_reset();
        set_id(1'b1, K_LOAD, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        step();
        set_id(1'b1, K_ALU, 3'd5, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0);
        flush = 1'b1;
        #1 check("flush_pc_en", 32'(pc_en), 32'd1);
        check("flush_if_id_en", 32'(if_id_en), 32'd1);
        check("flush_bubble", 32'(id_ex_bubble), 32'd1);
        check("flush_issue", 32'(issue), 32'd0);
        step();
        flush = 1'b0;
        // r5 must not have been recorded by the squashed instruction.
        set_id(1'b1, K_ALU, 3'd6, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0);
        #1 check("flush_no_record_issue", 32'(issue), 32'd1);
        check("flush_stall_cnt", 32'(stall_cnt), 32'd0);
        step();
        idle();

        // ---- same-cycle writeback and issue to r3: pending stays set
        do_reset();
        set_id(1'b1, K_LOAD, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        wb_valid = 1'b1;
        wb_rd    = 3'd3;
        #1 check("wb_same_issue", 32'(issue), 32'd1);
        step();
        wb_valid = 1'b0;
        set_id(1'b1, K_ALU, 3'd4, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0);
        #1 expect_stall("wb_same_pending");
        step();
        idle();

        // ---- reset in the middle of a LOAD r3 stall
        do_reset();
        set_id(1'b1, K_LOAD, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        step();
        set_id(1'b1, K_ALU, 3'd4, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1);
        #1 expect_stall("mid_c1");
        step();
        check("mid_stall_cnt", 32'(stall_cnt), 32'd1);
        #1 rst_n = 1'b0;
        #1 check("mid_rst_pc_en", 32'(pc_en), 32'd1);
        check("mid_rst_bubble", 32'(id_ex_bubble), 32'd0);
        check("mid_rst_issue", 32'(issue), 32'd0);
        check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;
        // Released before any clock edge: pending[r3] is already clear.
        #1 check("mid_rst_cleared_issue", 32'(issue), 32'd1);
        step();
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
